// File: rtl/chess_game_controller_if.sv
// Command/completion bus between the game sequencer (master) and the board datapath (slave).
interface chess_game_controller_if;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned PIECE_W = 4;

    logic               dp_initialize_board;
    logic               dp_move_piece;
    logic [COORD_W-1:0] dp_origin_x;
    logic [COORD_W-1:0] dp_origin_y;
    logic [COORD_W-1:0] dp_dest_x;
    logic [COORD_W-1:0] dp_dest_y;
    logic [PIECE_W-1:0] dp_piece;
    logic               dp_initialize_complete;
    logic               dp_move_complete;

    modport master (
        output dp_initialize_board, dp_move_piece,
        output dp_origin_x, dp_origin_y, dp_dest_x, dp_dest_y, dp_piece,
        input  dp_initialize_complete, dp_move_complete
    );

    modport slave (
        input  dp_initialize_board, dp_move_piece,
        input  dp_origin_x, dp_origin_y, dp_dest_x, dp_dest_y, dp_piece,
        output dp_initialize_complete, dp_move_complete
    );
endinterface

// File: rtl/chess_game_controller.sv
// Chess game sequencer: board init, turn/colour-checked move forwarding, datapath watchdog.
// Optional macro TURN_ENFORCE_EN enables turn alternation and the piece colour check.
module chess_game_controller #(
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       req_w,
    input  logic       req_b,
    input  logic [2:0] w_origin_x,
    input  logic [2:0] w_origin_y,
    input  logic [2:0] w_dest_x,
    input  logic [2:0] w_dest_y,
    input  logic [2:0] b_origin_x,
    input  logic [2:0] b_origin_y,
    input  logic [2:0] b_dest_x,
    input  logic [2:0] b_dest_y,
    input  logic [3:0] w_piece,
    input  logic [3:0] b_piece,
    chess_game_controller_if.master dp,
    output logic       ack_w,
    output logic       ack_b,
    output logic       reject_w,
    output logic       reject_b,
    output logic       turn,
    output logic       ready,
    output logic       fault,
    output logic [7:0] move_count
);
    localparam int unsigned COORD_W = 3;
    localparam int unsigned PIECE_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned WD_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_READY,
        S_MOVE_REQ, S_MOVE_WAIT, S_ACK, S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic               init_q, init_d;
    logic               move_q, move_d;
    logic               ack_w_q, ack_w_d;
    logic               ack_b_q, ack_b_d;
    logic               rej_w_q, rej_w_d;
    logic               rej_b_q, rej_b_d;
    logic               turn_q, turn_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               who_q, who_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d, dx_q, dx_d, dy_q, dy_d;
    logic [PIECE_W-1:0] piece_q, piece_d;

    logic w_colour_ok, b_colour_ok, w_valid, b_valid;
    logic in_ready, take_w, take_b, wd_expire;

    // Request legality and arbitration
    always_comb begin
`ifdef TURN_ENFORCE_EN
        w_colour_ok = (w_piece >= 4'd7) && (w_piece <= 4'd12);
        b_colour_ok = (b_piece >= 4'd1) && (b_piece <= 4'd6);
`else
        w_colour_ok = (w_piece != '0);
        b_colour_ok = (b_piece != '0);
`endif
        w_valid  = w_colour_ok && ({w_origin_x, w_origin_y} != {w_dest_x, w_dest_y});
        b_valid  = b_colour_ok && ({b_origin_x, b_origin_y} != {b_dest_x, b_dest_y});
        in_ready = (state_q == S_READY) && !start;
`ifdef TURN_ENFORCE_EN
        take_w = in_ready && req_w && !turn_q && w_valid;
        take_b = in_ready && req_b && turn_q && b_valid;
`else
        take_w = in_ready && req_w && w_valid;
        take_b = in_ready && req_b && !req_w && b_valid;
`endif
        wd_expire = ((wd_q + 16'd1) == TIMEOUT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_INIT_REQ;
            S_INIT_REQ:  state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (dp.dp_initialize_complete) state_d = S_READY;
                else if (wd_expire)            state_d = S_FAULT;
            end
            S_READY: begin
                if (start)                 state_d = S_INIT_REQ;
                else if (take_w || take_b) state_d = S_MOVE_REQ;
            end
            S_MOVE_REQ:  state_d = S_MOVE_WAIT;
            S_MOVE_WAIT: begin
                if (dp.dp_move_complete) state_d = S_ACK;
                else if (wd_expire)      state_d = S_FAULT;
            end
            S_ACK:       state_d = S_READY;
            S_FAULT:     if (start) state_d = S_INIT_REQ;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output / datapath register next values
    always_comb begin
        init_d  = (state_d == S_INIT_REQ);
        move_d  = (state_d == S_MOVE_REQ);
        ready_d = (state_d == S_READY);
        fault_d = (state_d == S_FAULT);
        ack_w_d = (state_d == S_ACK) && !who_q;
        ack_b_d = (state_d == S_ACK) && who_q;
        rej_w_d = req_w && !take_w;
        rej_b_d = req_b && !take_b;
        turn_d  = turn_q;
        cnt_d   = cnt_q;
        who_d   = who_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        piece_d = piece_q;
        wd_d    = '0;

        // Watchdog runs only while dwelling in a wait state; entry clears it
        if ((state_q == S_INIT_WAIT || state_q == S_MOVE_WAIT) && (state_d == state_q))
            wd_d = wd_q + 16'd1;

        if (take_w) begin
            who_d   = 1'b0;
            ox_d    = w_origin_x;
            oy_d    = w_origin_y;
            dx_d    = w_dest_x;
            dy_d    = w_dest_y;
            piece_d = w_piece;
        end else if (take_b) begin
            who_d   = 1'b1;
            ox_d    = b_origin_x;
            oy_d    = b_origin_y;
            dx_d    = b_dest_x;
            dy_d    = b_dest_y;
            piece_d = b_piece;
        end

        if (state_d == S_INIT_REQ) begin
            turn_d = 1'b0;
            cnt_d  = '0;
        end else if (state_q == S_ACK) begin
`ifdef TURN_ENFORCE_EN
            turn_d = !turn_q;
`endif
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_q  <= 1'b0;
            move_q  <= 1'b0;
            ack_w_q <= 1'b0;
            ack_b_q <= 1'b0;
            rej_w_q <= 1'b0;
            rej_b_q <= 1'b0;
            turn_q  <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            who_q   <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            piece_q <= '0;
        end else begin
            init_q  <= init_d;
            move_q  <= move_d;
            ack_w_q <= ack_w_d;
            ack_b_q <= ack_b_d;
            rej_w_q <= rej_w_d;
            rej_b_q <= rej_b_d;
            turn_q  <= turn_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            who_q   <= who_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            piece_q <= piece_d;
        end
    end

    assign dp.dp_initialize_board = init_q;
    assign dp.dp_move_piece       = move_q;
    assign dp.dp_origin_x         = ox_q;
    assign dp.dp_origin_y         = oy_q;
    assign dp.dp_dest_x           = dx_q;
    assign dp.dp_dest_y           = dy_q;
    assign dp.dp_piece            = piece_q;

    assign ack_w      = ack_w_q;
    assign ack_b      = ack_b_q;
    assign reject_w   = rej_w_q;
    assign reject_b   = rej_b_q;
    assign turn       = turn_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign move_count = cnt_q;
endmodule

// File: tb/tb_chess_game_controller.sv
// Directed bench for chess_game_controller: main instance (default TIMEOUT) plus a TIMEOUT=20 instance.
module tb_chess_game_controller;
`ifdef TURN_ENFORCE_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, req_w, req_b, init_cmp, move_cmp;
    logic [2:0] w_ox, w_oy, w_dx, w_dy, b_ox, b_oy, b_dx, b_dy;
    logic [3:0] w_piece, b_piece;

    logic       ack_w, ack_b, reject_w, reject_b, turn, ready, fault;
    logic [7:0] move_count;
    logic       wd_ack_w, wd_ack_b, wd_reject_w, wd_reject_b, wd_turn, wd_ready, wd_fault;
    logic [7:0] wd_move_count;

    int n_cmp = 0;
    int n_err = 0;
    logic turn_m;
    int   cnt_m;

    chess_game_controller_if dpa ();
    chess_game_controller_if dpb ();
    assign dpa.dp_initialize_complete = init_cmp;
    assign dpa.dp_move_complete       = move_cmp;
    assign dpb.dp_initialize_complete = init_cmp;
    assign dpb.dp_move_complete       = move_cmp;

    chess_game_controller dut (
        .clk(clk), .reset(reset), .start(start), .req_w(req_w), .req_b(req_b),
        .w_origin_x(w_ox), .w_origin_y(w_oy), .w_dest_x(w_dx), .w_dest_y(w_dy),
        .b_origin_x(b_ox), .b_origin_y(b_oy), .b_dest_x(b_dx), .b_dest_y(b_dy),
        .w_piece(w_piece), .b_piece(b_piece), .dp(dpa),
        .ack_w(ack_w), .ack_b(ack_b), .reject_w(reject_w), .reject_b(reject_b),
        .turn(turn), .ready(ready), .fault(fault), .move_count(move_count)
    );

    chess_game_controller #(.TIMEOUT(16'd20)) dut_wd (
        .clk(clk), .reset(reset), .start(start), .req_w(req_w), .req_b(req_b),
        .w_origin_x(w_ox), .w_origin_y(w_oy), .w_dest_x(w_dx), .w_dest_y(w_dy),
        .b_origin_x(b_ox), .b_origin_y(b_oy), .b_dest_x(b_dx), .b_dest_y(b_dy),
        .w_piece(w_piece), .b_piece(b_piece), .dp(dpb),
        .ack_w(wd_ack_w), .ack_b(wd_ack_b), .reject_w(wd_reject_w), .reject_b(wd_reject_b),
        .turn(wd_turn), .ready(wd_ready), .fault(wd_fault), .move_count(wd_move_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [3:0] pc, input logic [2:0] ox, oy, dx, dy);
        w_piece = pc; w_ox = ox; w_oy = oy; w_dx = dx; w_dy = dy;
    endtask

    task automatic set_b(input logic [3:0] pc, input logic [2:0] ox, oy, dx, dy);
        b_piece = pc; b_ox = ox; b_oy = oy; b_dx = dx; b_dy = dy;
    endtask

    // Accepted move: optional competing request, completion after lat wait cycles
    task automatic run_move(input bit blk, input int lat, input bit both);
        logic [3:0]  pc;
        logic [11:0] crd;
        pc  = blk ? b_piece : w_piece;
        crd = blk ? {b_ox, b_oy, b_dx, b_dy} : {w_ox, w_oy, w_dx, w_dy};
        req_w = !blk || both;
        req_b = blk || both;
        tick();
        req_w = 1'b0; req_b = 1'b0;
        check("mv_strobe", 32'(dpa.dp_move_piece), 32'd1);
        check("mv_piece", 32'(dpa.dp_piece), 32'(pc));
        check("mv_coords", 32'({dpa.dp_origin_x, dpa.dp_origin_y, dpa.dp_dest_x, dpa.dp_dest_y}), 32'(crd));
        check("mv_rejects", 32'({reject_w, reject_b}), blk ? 32'({both, 1'b0}) : 32'({1'b0, both}));
        check("mv_ready_low", 32'(ready), 32'd0);
        tick();
        check("mv_strobe_1cyc", 32'(dpa.dp_move_piece), 32'd0);
        repeat (lat) tick();
        move_cmp = 1'b1;
        tick();
        move_cmp = 1'b0;
        check("ack", 32'({ack_w, ack_b}), blk ? 32'd1 : 32'd2);
        check("turn_in_ack", 32'(turn), 32'(turn_m));
        tick();
        if (TURN_EN) turn_m = !turn_m;
        if (cnt_m < 255) cnt_m++;
        check("ack_1cyc", 32'({ack_w, ack_b}), 32'd0);
        check("ready_back", 32'(ready), 32'd1);
        check("turn", 32'(turn), 32'(turn_m));
        check("move_count", 32'(move_count), 32'(cnt_m));
    endtask

    // Refused request while in S_READY
    task automatic try_reject(input bit blk, input string tag);
        if (blk) req_b = 1'b1; else req_w = 1'b1;
        tick();
        req_w = 1'b0; req_b = 1'b0;
        check(tag, 32'({reject_w, reject_b}), blk ? 32'd1 : 32'd2);
        check({tag, "_nomove"}, 32'(dpa.dp_move_piece), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        tick();
        check({tag, "_1cyc"}, 32'({reject_w, reject_b}), 32'd0);
    endtask

    initial begin
        int n_init;
        reset = 1'b1; start = 1'b0; req_w = 1'b0; req_b = 1'b0;
        init_cmp = 1'b0; move_cmp = 1'b0;
        set_w(4'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        set_b(4'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        turn_m = 1'b0; cnt_m = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_flags", 32'({ready, fault, turn}), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_strobes", 32'({dpa.dp_initialize_board, dpa.dp_move_piece, ack_w, ack_b, reject_w, reject_b}), 32'd0);
        check("rst_dp", 32'({dpa.dp_origin_x, dpa.dp_origin_y, dpa.dp_dest_x, dpa.dp_dest_y, dpa.dp_piece}), 32'd0);

        // Board init with a slow datapath
        start = 1'b1;
        tick();
        start = 1'b0;
        check("init_strobe", 32'(dpa.dp_initialize_board), 32'd1);
        n_init = 0;
        repeat (300) begin
            tick();
            if (dpa.dp_initialize_board) n_init++;
        end
        check("init_single_pulse", 32'(n_init), 32'd0);
        check("init_wait_ready", 32'({ready, fault}), 32'd0);
        init_cmp = 1'b1;
        tick();
        init_cmp = 1'b0;
        check("init_ready", 32'(ready), 32'd1);
        check("init_count", 32'(move_count), 32'd0);

        // Stray completion in S_READY is ignored
        move_cmp = 1'b1;
        tick();
        move_cmp = 1'b0;
        check("stray_cmp", 32'({ack_w, ack_b, dpa.dp_move_piece, ready}), 32'd1);

        set_w(4'd0, 3'd1, 3'd1, 3'd1, 3'd2);
        try_reject(1'b0, "rej_empty");
        set_w(4'd7, 3'd3, 3'd3, 3'd3, 3'd3);
        try_reject(1'b0, "rej_same_sq");

        set_w(4'd7, 3'd4, 3'd6, 3'd4, 3'd4);
        run_move(1'b0, 4, 1'b0);

`ifdef TURN_ENFORCE_EN
        set_w(4'd8, 3'd1, 3'd7, 3'd2, 3'd5);
        try_reject(1'b0, "rej_out_of_turn");
        set_b(4'd7, 3'd4, 3'd1, 3'd4, 3'd3);
        try_reject(1'b1, "rej_wrong_colour");
        set_b(4'd1, 3'd4, 3'd1, 3'd4, 3'd3);
        run_move(1'b1, 2, 1'b0);
        set_w(4'd9, 3'd6, 3'd7, 3'd5, 3'd5);
        run_move(1'b0, 0, 1'b1);
`else
        set_w(4'd8, 3'd1, 3'd7, 3'd2, 3'd5);
        set_b(4'd1, 3'd4, 3'd1, 3'd4, 3'd3);
        run_move(1'b0, 0, 1'b1);
        set_w(4'd10, 3'd6, 3'd7, 3'd5, 3'd5);
        run_move(1'b0, 3, 1'b0);
        set_b(4'd7, 3'd2, 3'd2, 3'd2, 3'd0);
        run_move(1'b1, 1, 1'b0);
`endif

        // Requests and start while a move is in flight
        set_w(4'd12, 3'd0, 3'd0, 3'd7, 3'd7);
        set_b(4'd2, 3'd7, 3'd7, 3'd0, 3'd0);
        if (turn_m) req_b = 1'b1; else req_w = 1'b1;
        tick();
        req_w = 1'b1; req_b = 1'b1;
        tick();
        req_w = 1'b0; req_b = 1'b0;
        check("rej_busy", 32'({reject_w, reject_b}), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored", 32'(dpa.dp_initialize_board), 32'd0);
        move_cmp = 1'b1;
        tick();
        move_cmp = 1'b0;
        check("busy_ack", 32'({ack_w, ack_b}), turn_m ? 32'd1 : 32'd2);
        tick();
        if (TURN_EN) turn_m = !turn_m;
        cnt_m++;
        check("busy_count", 32'(move_count), 32'(cnt_m));

        // Drive move_count into saturation
        for (int i = 0; i < 260; i++) begin
            if (turn_m) begin set_b(4'd3, 3'd0, 3'd0, 3'd0, 3'd1); req_b = 1'b1; end
            else        begin set_w(4'd11, 3'd0, 3'd0, 3'd0, 3'd1); req_w = 1'b1; end
            tick();
            req_w = 1'b0; req_b = 1'b0;
            tick();
            move_cmp = 1'b1;
            tick();
            move_cmp = 1'b0;
            tick();
            if (TURN_EN) turn_m = !turn_m;
            if (cnt_m < 255) cnt_m++;
        end
        check("sat_count", 32'(move_count), 32'd255);
        check("sat_turn", 32'(turn), 32'(turn_m));

        // New game from S_READY clears the scoreboard
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_init", 32'(dpa.dp_initialize_board), 32'd1);
        check("restart_clear", 32'({turn, move_count}), 32'd0);

        // Watchdog on the TIMEOUT=20 instance
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        init_cmp = 1'b1;
        tick();
        init_cmp = 1'b0;
        check("wd_ready", 32'(wd_ready), 32'd1);
        set_w(4'd7, 3'd0, 3'd1, 3'd0, 3'd3);
        req_w = 1'b1;
        tick();
        req_w = 1'b0;
        check("wd_strobe", 32'(dpb.dp_move_piece), 32'd1);
        tick();
        repeat (19) tick();
        check("wd_not_yet", 32'(wd_fault), 32'd0);
        tick();
        check("wd_fault", 32'({wd_fault, wd_ready}), 32'd2);
        check("main_no_fault", 32'(fault), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wd_restart", 32'({dpb.dp_initialize_board, wd_fault}), 32'd2);
        check("main_start_ignored", 32'(dpa.dp_initialize_board), 32'd0);
        tick();
        check("wd_init_1cyc", 32'(dpb.dp_initialize_board), 32'd0);

        // Reset while the main instance sits in S_MOVE_WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_flags", 32'({ready, fault, turn, ack_w, ack_b, reject_w, reject_b}), 32'd0);
        check("mid_rst_count", 32'(move_count), 32'd0);
        check("mid_rst_dp", 32'({dpa.dp_initialize_board, dpa.dp_move_piece, dpa.dp_origin_x,
                                 dpa.dp_origin_y, dpa.dp_dest_x, dpa.dp_dest_y, dpa.dp_piece}), 32'd0);
        req_w = 1'b1;
        move_cmp = 1'b1;
        tick();
        req_w = 1'b0;
        move_cmp = 1'b0;
        check("idle_reject", 32'({reject_w, dpa.dp_move_piece, ack_w, ready}), 32'd8);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("idle_start", 32'(dpa.dp_initialize_board), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
